// File: rtl/key_bank_pkg.sv
// rtl/key_bank_pkg.sv - shared FSM encoding, block constants and byte-swap helper for key_bank
package key_bank_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ZERO = 1'b1
    } state_t;

    localparam int AES_BLOCK_BITS = 128;
    localparam int MAX_WORD_SIZE  = 64;

    // Reverses the low nbytes bytes of w; callers truncate the result to their word width.
    function automatic logic [MAX_WORD_SIZE-1:0] byte_swap(input logic [MAX_WORD_SIZE-1:0] w,
                                                           input int nbytes);
        byte_swap = '0;
        for (int i = 0; i < MAX_WORD_SIZE / 8; i++) begin
            if (i < nbytes) begin
                byte_swap[8*i +: 8] = w[8*(nbytes-1-i) +: 8];
            end
        end
    endfunction

endpackage

// File: rtl/key_bank_if.sv
// rtl/key_bank_if.sv - write/increment/zeroize/read bundle between software side and key_bank
interface key_bank_if #(
    parameter int SLOTS     = 4,
    parameter int WORDS     = 4,
    parameter int WORD_SIZE = 32
);
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BLK    = WORDS * WORD_SIZE;

    logic                 wen;
    logic [SLOT_W-1:0]    wslot;
    logic [IDX_W-1:0]     widx;
    logic [WORD_SIZE-1:0] wdata;
    logic                 inc;
    logic [SLOT_W-1:0]    inc_slot;
    logic                 zeroize;
    logic                 busy;
    logic [SLOT_W-1:0]    rslot;
    logic [BLK-1:0]       rdata;
    logic                 rvalid;
    logic [SLOTS-1:0]     valid;

    modport master (
        output wen, wslot, widx, wdata, inc, inc_slot, zeroize, rslot,
        input  busy, rdata, rvalid, valid
    );

    modport slave (
        input  wen, wslot, widx, wdata, inc, inc_slot, zeroize, rslot,
        output busy, rdata, rvalid, valid
    );

endinterface

// File: rtl/key_slot.sv
// rtl/key_slot.sv - one block register with written-word mask, CTR increment and clear
module key_slot #(
    parameter int WORDS     = 4,
    parameter int WORD_SIZE = 32,
    parameter int CTR_WIDTH = 32,
    parameter int IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       wen,
    input  logic [IDX_W-1:0]           widx,
    input  logic [WORD_SIZE-1:0]       wword,
    input  logic                       inc,
    output logic [WORDS*WORD_SIZE-1:0] data,
    output logic                       valid
);

    logic [WORDS-1:0] mask;

    assign valid = &mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            mask <= '0;
        end else if (clr) begin
            data <= '0;
            mask <= '0;
        end else if (wen) begin
            // widx 0 is the most-significant word and restarts the load sequence
            for (int w = 0; w < WORDS; w++) begin
                if (widx == IDX_W'(w)) begin
                    data[(WORDS-1-w)*WORD_SIZE +: WORD_SIZE] <= wword;
                    mask <= (w == 0) ? WORDS'(1) : (mask | (WORDS'(1) << w));
                end
            end
        end else if (inc && valid) begin
            data[CTR_WIDTH-1:0] <= data[CTR_WIDTH-1:0] + CTR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/key_bank.sv
// rtl/key_bank.sv - multi-slot AES key/IV/counter store with sequenced zeroize
module key_bank
    import key_bank_pkg::*;
#(
    parameter int SLOTS     = 4,
    parameter int WORDS     = AES_BLOCK_BITS / 32,
    parameter int WORD_SIZE = 32,
    parameter int CTR_WIDTH = 32,
    parameter int BYTE_SWAP = 1
) (
    input logic        clk,
    input logic        rst_n,
    key_bank_if.slave  bus
);

    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int BLK    = WORDS * WORD_SIZE;

    state_t               state;
    logic [SLOT_W-1:0]    zcnt;
    logic                 accept;
    logic                 wr_go;
    logic                 inc_go;
    logic [WORD_SIZE-1:0] wword;
    logic [BLK-1:0]       slot_data [SLOTS];
    logic [SLOTS-1:0]     slot_valid;

    // Zeroize outranks software writes/increments in the cycle it is sampled.
    assign accept = (state == ST_IDLE) && !bus.zeroize;
    assign wr_go  = accept && bus.wen;
    assign inc_go = accept && bus.inc;
    assign bus.busy  = (state == ST_ZERO);
    assign bus.valid = slot_valid;

    generate
        if (BYTE_SWAP != 0) begin : g_swap
            assign wword = WORD_SIZE'(byte_swap(MAX_WORD_SIZE'(bus.wdata), WORD_SIZE / 8));
        end else begin : g_noswap
            assign wword = bus.wdata;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            zcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.zeroize) begin
                        state <= ST_ZERO;
                        zcnt  <= '0;
                    end
                end
                ST_ZERO: begin
                    if (zcnt == SLOT_W'(SLOTS - 1)) begin
                        state <= ST_IDLE;
                        zcnt  <= '0;
                    end else begin
                        zcnt <= zcnt + SLOT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    genvar s;
    generate
        for (s = 0; s < SLOTS; s++) begin : g_slot
            logic slot_wen;
            logic slot_inc;
            logic slot_clr;

            assign slot_wen = wr_go && (bus.wslot == SLOT_W'(s));
            assign slot_inc = inc_go && (bus.inc_slot == SLOT_W'(s)) && !slot_wen;
            assign slot_clr = (state == ST_ZERO) && (zcnt == SLOT_W'(s));

            key_slot #(
                .WORDS     (WORDS),
                .WORD_SIZE (WORD_SIZE),
                .CTR_WIDTH (CTR_WIDTH)
            ) u_slot (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (slot_clr),
                .wen   (slot_wen),
                .widx  (bus.widx),
                .wword (wword),
                .inc   (slot_inc),
                .data  (slot_data[s]),
                .valid (slot_valid[s])
            );
        end
    endgenerate

    // Unmatched rslot values fall through to zero.
    always_comb begin
        bus.rdata  = '0;
        bus.rvalid = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (bus.rslot == SLOT_W'(i)) begin
                bus.rdata  = slot_data[i];
                bus.rvalid = slot_valid[i];
            end
        end
    end

endmodule

// File: tb/tb_key_bank.sv
// tb/tb_key_bank.sv - scoreboard bench for key_bank (swapped 4-slot and unswapped 3-slot builds)
module tb_key_bank;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    key_bank_if #(.SLOTS(4), .WORDS(4), .WORD_SIZE(32)) bus_a ();
    key_bank_if #(.SLOTS(3), .WORDS(4), .WORD_SIZE(32)) bus_b ();

    key_bank #(.SLOTS(4), .WORDS(4), .WORD_SIZE(32), .CTR_WIDTH(32), .BYTE_SWAP(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    key_bank #(.SLOTS(3), .WORDS(4), .WORD_SIZE(32), .CTR_WIDTH(32), .BYTE_SWAP(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    typedef struct {
        int           d;
        logic [127:0] rdata;
        logic         rvalid;
        logic [3:0]   valid;
        logic         busy;
        string        name;
    } exp_t;

    exp_t         q[$];
    exp_t         e;
    int           tests   = 0;
    int           fails   = 0;
    logic         chk_req = 1'b0;
    logic         end_req = 1'b0;
    logic [127:0] act_rdata;
    logic         act_rvalid;
    logic [3:0]   act_valid;
    logic         act_busy;

    always @(negedge clk) begin
        if (chk_req) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL no_expectation: sample taken with empty scoreboard, required one entry");
            end else begin
                e = q.pop_front();
                if (e.d == 0) begin
                    act_rdata  = bus_a.rdata;
                    act_rvalid = bus_a.rvalid;
                    act_valid  = bus_a.valid;
                    act_busy   = bus_a.busy;
                end else begin
                    act_rdata  = bus_b.rdata;
                    act_rvalid = bus_b.rvalid;
                    act_valid  = {1'b0, bus_b.valid};
                    act_busy   = bus_b.busy;
                end
                if (act_rdata !== e.rdata || act_rvalid !== e.rvalid ||
                    act_valid !== e.valid || act_busy !== e.busy) begin
                    fails++;
                    $display("FAIL %s: got rdata=%h rvalid=%b valid=%b busy=%b, want rdata=%h rvalid=%b valid=%b busy=%b",
                             e.name, act_rdata, act_rvalid, act_valid, act_busy,
                             e.rdata, e.rvalid, e.valid, e.busy);
                end
            end
        end
        if (end_req) begin
            tests++;
            if (q.size() != 0) begin
                fails++;
                $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus_a.wen = 1'b0; bus_a.inc = 1'b0; bus_a.zeroize = 1'b0;
        bus_b.wen = 1'b0; bus_b.inc = 1'b0; bus_b.zeroize = 1'b0;
        chk_req = 1'b0;
    endtask

    task automatic set_wr(input int d, input int s, input int i, input logic [31:0] v);
        if (d == 0) begin
            bus_a.wen = 1'b1; bus_a.wslot = 2'(s); bus_a.widx = 2'(i); bus_a.wdata = v;
        end else begin
            bus_b.wen = 1'b1; bus_b.wslot = 2'(s); bus_b.widx = 2'(i); bus_b.wdata = v;
        end
    endtask

    task automatic set_inc(input int d, input int s);
        if (d == 0) begin
            bus_a.inc = 1'b1; bus_a.inc_slot = 2'(s);
        end else begin
            bus_b.inc = 1'b1; bus_b.inc_slot = 2'(s);
        end
    endtask

    task automatic wr(input int d, input int s, input int i, input logic [31:0] v);
        set_wr(d, s, i, v);
        step();
    endtask

    task automatic load(input int d, input int s, input logic [127:0] raw);
        for (int i = 0; i < 4; i++) begin
            wr(d, s, i, raw[127-32*i -: 32]);
        end
    endtask

    task automatic chk(input int d, input int s, input logic [127:0] r, input logic rv,
                       input logic [3:0] v, input logic b, input string n);
        exp_t x;
        x.d = d; x.rdata = r; x.rvalid = rv; x.valid = v; x.busy = b; x.name = n;
        q.push_back(x);
        if (d == 0) bus_a.rslot = 2'(s);
        else        bus_b.rslot = 2'(s);
        chk_req = 1'b1;
        step();
    endtask

    logic [127:0] zb [4];

    initial begin
        bus_a.wen = 0; bus_a.wslot = 0; bus_a.widx = 0; bus_a.wdata = 0;
        bus_a.inc = 0; bus_a.inc_slot = 0; bus_a.zeroize = 0; bus_a.rslot = 0;
        bus_b.wen = 0; bus_b.wslot = 0; bus_b.widx = 0; bus_b.wdata = 0;
        bus_b.inc = 0; bus_b.inc_slot = 0; bus_b.zeroize = 0; bus_b.rslot = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk(0, 0, 128'h0, 0, 4'b0000, 0, "reset_state_a");
        chk(1, 0, 128'h0, 0, 4'b0000, 0, "reset_state_b");

        wr(0, 1, 0, 32'h00010203);
        wr(0, 1, 1, 32'h04050607);
        wr(0, 1, 2, 32'h08090a0b);
        chk(0, 1, 128'h03020100_07060504_0b0a0908_00000000, 0, 4'b0000, 0, "partial_load");
        wr(0, 1, 3, 32'h0c0d0e0f);
        chk(0, 1, 128'h03020100_07060504_0b0a0908_0f0e0d0c, 1, 4'b0010, 0, "full_load_swap");

        load(0, 0, 128'h01000000_01000000_01000000_ffffffff);
        chk(0, 0, 128'h00000001_00000001_00000001_ffffffff, 1, 4'b0011, 0, "ctr_preload");
        set_inc(0, 0); step();
        chk(0, 0, 128'h00000001_00000001_00000001_00000000, 1, 4'b0011, 0, "ctr_wrap");
        set_inc(0, 2); step();
        chk(0, 2, 128'h0, 0, 4'b0011, 0, "inc_invalid_slot");

        set_wr(0, 0, 3, 32'haabbccdd); set_inc(0, 0); step();
        chk(0, 0, 128'h00000001_00000001_00000001_ddccbbaa, 1, 4'b0011, 0, "wr_beats_inc");
        set_wr(0, 0, 3, 32'h00000000); set_inc(0, 1); step();
        chk(0, 0, 128'h00000001_00000001_00000001_00000000, 1, 4'b0011, 0, "wr_other_slot");
        chk(0, 1, 128'h03020100_07060504_0b0a0908_0f0e0d0d, 1, 4'b0011, 0, "inc_other_slot");

        wr(0, 1, 0, 32'h11223344);
        chk(0, 1, 128'h44332211_07060504_0b0a0908_0f0e0d0d, 0, 4'b0001, 0, "restart_load");
        wr(0, 1, 1, 32'h55667788);
        wr(0, 1, 2, 32'h99aabbcc);
        chk(0, 1, 128'h44332211_88776655_ccbbaa99_0f0e0d0d, 0, 4'b0001, 0, "reload_partial");
        wr(0, 1, 3, 32'hddeeff00);
        chk(0, 1, 128'h44332211_88776655_ccbbaa99_00ffeedd, 1, 4'b0011, 0, "reload_done");

        load(0, 2, {4{32'h22222222}});
        load(0, 3, {4{32'h33333333}});
        chk(0, 3, {4{32'h33333333}}, 1, 4'b1111, 0, "all_loaded");

        zb[0] = 128'h00000001_00000001_00000001_00000000;
        zb[1] = 128'h44332211_88776655_ccbbaa99_00ffeedd;
        zb[2] = {4{32'h22222222}};
        zb[3] = {4{32'h33333333}};
        bus_a.zeroize = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                set_wr(0, 0, 0, 32'h12345678);
                set_inc(0, 3);
            end
            if (k == 2) bus_a.zeroize = 1'b1;
            chk(0, k, zb[k], 1, 4'b1111 << k, 1, "zeroize_busy");
        end
        chk(0, 0, 128'h0, 0, 4'b0000, 0, "zeroize_done_slot0");
        chk(0, 3, 128'h0, 0, 4'b0000, 0, "no_queued_zeroize");

        load(0, 3, {4{32'h33333333}});
        wr(0, 2, 0, 32'h01020304);
        bus_a.zeroize = 1'b1;
        step();
        rst_n = 1'b0;
        chk(0, 3, 128'h0, 0, 4'b0000, 0, "async_reset_mid_zeroize");
        rst_n = 1'b1;
        chk(0, 2, 128'h0, 0, 4'b0000, 0, "after_reset_release");

        load(1, 0, 128'h00010203_04050607_08090a0b_0c0d0e0f);
        chk(1, 0, 128'h00010203_04050607_08090a0b_0c0d0e0f, 1, 4'b0001, 0, "noswap_load");
        chk(1, 3, 128'h0, 0, 4'b0001, 0, "rslot_out_of_range");
        set_wr(1, 3, 0, 32'hdeadbeef); set_inc(1, 3); step();
        chk(1, 0, 128'h00010203_04050607_08090a0b_0c0d0e0f, 1, 4'b0001, 0, "oor_wr_inc_ignored");
        set_inc(1, 0); step();
        chk(1, 0, 128'h00010203_04050607_08090a0b_0c0d0e10, 1, 4'b0001, 0, "noswap_inc");

        end_req = 1'b1;
        step();
        end_req = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
